// File: rtl/seq_datapath_if.sv
// Command/result bus between the CPU controller and seq_datapath.
// The controller drives the command fields; the datapath returns handshake, result and flags.
interface seq_datapath_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned PC_W = 8
);
    localparam int unsigned AW = $clog2(NREG);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_rn;
    logic [AW-1:0] cmd_rm;
    logic [AW-1:0] cmd_rd;
    logic [1:0]    cmd_shift;
    logic          cmd_sel_a;
    logic          cmd_sel_b;
    logic [1:0]    cmd_alu_op;
    logic          cmd_status_en;
    logic          cmd_wr;
    logic [1:0]    cmd_wb_sel;
    logic [W-1:0]  imm5;
    logic [W-1:0]  imm8;
    logic [PC_W-1:0] pc;
    logic [W-1:0]  mdata;
    logic          done;
    logic [W-1:0]  datapath_out;
    logic          Z_out;
    logic          N_out;
    logic          V_out;

    modport master (
        output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_sel_a, cmd_sel_b,
               cmd_alu_op, cmd_status_en, cmd_wr, cmd_wb_sel, imm5, imm8, pc, mdata,
        input  cmd_ready, done, datapath_out, Z_out, N_out, V_out
    );

    modport slave (
        input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_sel_a, cmd_sel_b,
               cmd_alu_op, cmd_status_en, cmd_wr, cmd_wb_sel, imm5, imm8, pc, mdata,
        output cmd_ready, done, datapath_out, Z_out, N_out, V_out
    );
endinterface

// File: rtl/seq_datapath.sv
// Self-sequencing register/shift/ALU datapath: one command per handshake,
// walked through read A, read B, execute and writeback by an internal FSM.
module seq_datapath #(
    parameter int unsigned W    = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned PC_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_datapath_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] EXEC = 3'd3;
    localparam logic [2:0] WB   = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       accept;

    // Command fields captured at acceptance
    logic [AW-1:0]   rn_q;
    logic [AW-1:0]   rm_q;
    logic [AW-1:0]   rd_q;
    logic [1:0]      shift_q;
    logic            sel_a_q;
    logic            sel_b_q;
    logic [1:0]      alu_op_q;
    logic            status_en_q;
    logic            wr_q;
    logic [1:0]      wb_sel_q;
    logic [W-1:0]    imm5_q;
    logic [W-1:0]    imm8_q;
    logic [PC_W-1:0] pc_q;
    logic [W-1:0]    mdata_q;

    logic [W-1:0] regs [NREG];
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] c_q;
    logic         z_q;
    logic         n_q;
    logic         v_q;
    logic         done_q;

    logic [W-1:0] shifted;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic         alu_v;
    logic [W-1:0] wb_val;

    assign bus.cmd_ready    = rst_n && (state_q == IDLE);
    assign accept           = bus.cmd_valid && bus.cmd_ready;
    assign bus.done         = done_q;
    assign bus.datapath_out = c_q;
    assign bus.Z_out        = z_q;
    assign bus.N_out        = n_q;
    assign bus.V_out        = v_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Fixed five-step walk once a command is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter, operand selects, ALU and signed-overflow detect
    always_comb begin
        shifted = b_q;
        case (shift_q)
            2'b01:   shifted = {b_q[W-2:0], 1'b0};
            2'b10:   shifted = {1'b0, b_q[W-1:1]};
            2'b11:   shifted = {b_q[W-1], b_q[W-1:1]};
            default: shifted = b_q;
        endcase

        alu_a = sel_a_q ? '0 : a_q;
        alu_b = sel_b_q ? imm5_q : shifted;

        alu_res = '0;
        alu_v   = 1'b0;
        case (alu_op_q)
            OP_ADD: begin
                alu_res = alu_a + alu_b;
                alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            OP_SUB: begin
                alu_res = alu_a + (~alu_b) + W'(1);
                alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            OP_AND:  alu_res = alu_a & alu_b;
            default: alu_res = ~alu_b;
        endcase

        wb_val = c_q;
        case (wb_sel_q)
            2'b01:   wb_val = W'(pc_q);
            2'b10:   wb_val = imm8_q;
            2'b11:   wb_val = mdata_q;
            default: wb_val = c_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            shift_q     <= '0;
            sel_a_q     <= 1'b0;
            sel_b_q     <= 1'b0;
            alu_op_q    <= '0;
            status_en_q <= 1'b0;
            wr_q        <= 1'b0;
            wb_sel_q    <= '0;
            imm5_q      <= '0;
            imm8_q      <= '0;
            pc_q        <= '0;
            mdata_q     <= '0;
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == EXEC);
            if (accept) begin
                rn_q        <= bus.cmd_rn;
                rm_q        <= bus.cmd_rm;
                rd_q        <= bus.cmd_rd;
                shift_q     <= bus.cmd_shift;
                sel_a_q     <= bus.cmd_sel_a;
                sel_b_q     <= bus.cmd_sel_b;
                alu_op_q    <= bus.cmd_alu_op;
                status_en_q <= bus.cmd_status_en;
                wr_q        <= bus.cmd_wr;
                wb_sel_q    <= bus.cmd_wb_sel;
                imm5_q      <= bus.imm5;
                imm8_q      <= bus.imm8;
                pc_q        <= bus.pc;
                mdata_q     <= bus.mdata;
            end
            case (state_q)
                RD_A: a_q <= regs[rn_q];
                RD_B: b_q <= regs[rm_q];
                EXEC: begin
                    c_q <= alu_res;
                    if (status_en_q) begin
                        z_q <= (alu_res == '0);
                        n_q <= alu_res[W-1];
                        v_q <= alu_v;
                    end
                end
                WB: if (wr_q) regs[rd_q] <= wb_val;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised, self-sequencing successor to the single-cycle-controlled register/ALU datapath. It accepts one register-transfer command per valid/ready handshake and sequences the operand reads, shift, ALU, status update and writeback itself. The CPU controller issues whole operations instead of per-cycle enables. It sits between the instruction decoder/controller and memory: `mdata` comes in from RAM, and `datapath_out` goes out to address and data buses.

## Interface
- `W`, 16: datapath and register width; ≥ 8.
- `NREG`, 8: number of general registers; power of two ≥ 2. `AW = $clog2(NREG)` is derived, not a parameter.
- `PC_W`, 8: program-counter width; ≤ `W`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_rn`, `cmd_rm`, `cmd_rd`  in  `AW` each  operand A register, operand B register, destination register.
- `cmd_shift`  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- `cmd_sel_a`  in  1  1: A operand = 0.
- `cmd_sel_b`  in  1  1: B operand = `imm5`, bypassing the shifter.
- `cmd_alu_op`  in  2  00 ADD, 01 SUB (A−B), 10 AND, 11 NOT B.
- `cmd_status_en`  in  1  update Z/N/V.
- `cmd_wr`  in  1  perform register writeback.
- `cmd_wb_sel`  in  2  00 ALU result, 01 zero-extended `pc`, 10 `imm8`, 11 `mdata`.
- `imm5`, `imm8`  in  `W` each  pre-sign-extended immediates.
- `pc`  in  `PC_W`  current PC.
- `mdata`  in  `W`  memory read data.
- `done`  out  1  one-cycle pulse in the command's writeback cycle.
- `datapath_out`  out  `W`  result register C.
- `Z_out`, `N_out`, `V_out`  out  1 each  status flags.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. All `cmd_*` fields, `imm5`, `imm8`, `pc` and `mdata` are latched at acceptance. Later input changes do not affect that command.
- `cmd_ready = rst_n && (state == IDLE)`. While the block is busy, `cmd_valid` is ignored and nothing is queued.
- FSM states IDLE → RD_A → RD_B → EXEC → WB → IDLE, one cycle each, unconditional after acceptance:
  - RD_A: A ← R[rn].
  - RD_B: B ← R[rm].
  - EXEC:
    - C ← ALU(`sel_a` ? 0 : A, `sel_b` ? `imm5` : shift(B)).
    - If `status_en`: Z ← (result == 0), N ← result[W−1], V ← signed overflow for ADD/SUB, V ← 0 for AND/NOT.
    - If `status_en` = 0: flags hold.
  - WB:
    - If `wr`: R[rd] ← wb mux, where source 00 is the C value written in EXEC.
    - `done` = 1 whether or not `wr` is set.
- Arithmetic: modulo 2^W. SUB is A + ~B + 1.
  - V on ADD: A and B have the same sign and the result sign differs.
  - V on SUB: A and B signs differ and the result sign differs from A.
- Commands with `wr = 1`, `cmd_wb_sel ≠ 00` still execute the ALU and update C and the flags. Selects 01/10/11 are how loads, MOV-immediate and link are issued.
- rd == rn or rd == rm: reads use the old values, because reads complete before WB.
- A following command reading rd sees the newly written value, because its RD_A is at least 2 cycles after WB.

## Timing
- Reset: when `rst_n` = 0 at an edge:
  - state ← IDLE.
  - All R[i], A, B, C ← 0.
  - Z/N/V ← 0; `done` ← 0.
  - `cmd_ready` is 0 combinationally while `rst_n` = 0.
- Reset mid-command, in any state: the command is aborted with no register write and no `done`. Outputs are as above on the next cycle.
- Latency: if accepted at edge t, C and flags are valid after edge t+3 and the register write lands at edge t+4. `done` is high during cycle t+3..t+4, i.e. the WB state.
- `cmd_ready` returns high the cycle after WB, so peak throughput is one command per 5 cycles.
- `datapath_out` and the flags are registered outputs and hold between commands.

## Test plan
- Reset then load: reset with all registers pre-dirtied. Then issue cmd wr=1, wb_sel=10, rd=0, imm8=0x0007. Required: `done` exactly 4 cycles after acceptance, and a later read of R0 gives 0x0007. Every register reads 0x0000 after reset.
- Shift+ADD: R0=0x0007, R1=0x0002. Issue rn=0, rm=1, shift=01, ADD, rd=2, wb_sel=00, status_en=1. Required: `datapath_out` = 0x000B, R2 = 0x000B, Z/N/V = 0/0/0.
- Overflow: R3=0x7FFF loaded via mdata, R4=0x0001. Issue ADD rn=3, rm=4, status_en=1. Required: result 0x8000, Z/N/V = 0/1/1.
- Then SUB rn=3, rm=3. Required: result 0x0000, Z/N/V = 1/0/0.
- Then ASR1 NOT on B=0x8000, status_en=0. Required: result 0x3FFF, flags unchanged.
- Backpressure and latching: hold `cmd_valid` = 1 with changing fields during a busy command. Required: no second acceptance until `cmd_ready` rises, and the first command's result uses only its latched fields.
- Abort: assert `rst_n` = 0 in EXEC of a cmd with wr=1, rd=5. Required: R5 stays 0, `done` is never pulsed, and `cmd_ready` = 1 on the first cycle after `rst_n` returns to 1.
